// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: sequences a serial CRC engine, feeding it byte frames LSB-first and
// collecting its serial CRC into a parallel result. Define CRC_OUT_REFLECT_EN for bit-reversed OUT_CRC.
module crc_frame_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CRC_W     = 8,
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              ENG_RST,
  output logic              ENG_DATA,
  output logic              ENG_ACTIVE,
  input  logic              ENG_CRC,
  input  logic              ENG_VALID,
  output logic [CRC_W-1:0]  OUT_CRC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              ERR
);
  localparam int unsigned BitW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CrcIdxW = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam int unsigned CntW    = $clog2(MAX_BYTES + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
`ifdef CRC_OUT_REFLECT_EN
  localparam bit Reflect = 1'b1;
`else
  localparam bit Reflect = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StClr, StGap, StShift, StDrain, StHold, StAbort} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  shift_q, pf_data_q;
  logic               last_q, pf_last_q, pf_valid_q;
  logic [BitW-1:0]    bit_q;
  logic [CntW-1:0]    cnt_q;
  logic [CrcIdxW-1:0] crc_idx_q;
  logic [TmoW-1:0]    tmo_q;

  logic               accept, bit_end, overlength, underrun;
  logic [CrcIdxW-1:0] crc_pos;

  always_comb begin
    accept     = IN_VALID & IN_READY;
    bit_end    = (bit_q == BitW'(DATA_W - 1));
    overlength = accept & (cnt_q == CntW'(MAX_BYTES)) & ~IN_LAST;
    // A byte accepted on the final bit arrives in time and is not an underrun.
    underrun   = bit_end & ~last_q & ~pf_valid_q & ~accept;
    crc_pos    = Reflect ? (CrcIdxW'(CRC_W - 1) - crc_idx_q) : crc_idx_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      pf_data_q  <= '0;
      last_q     <= 1'b0;
      pf_last_q  <= 1'b0;
      pf_valid_q <= 1'b0;
      bit_q      <= '0;
      cnt_q      <= '0;
      crc_idx_q  <= '0;
      tmo_q      <= '0;
      IN_READY   <= 1'b0;
      ENG_RST    <= 1'b0;
      ENG_DATA   <= 1'b0;
      ENG_ACTIVE <= 1'b0;
      OUT_CRC    <= '0;
      OUT_VALID  <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      ERR <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ENG_RST  <= 1'b1;
          IN_READY <= 1'b1;
          if (accept) begin
            shift_q  <= IN_DATA;
            last_q   <= IN_LAST;
            cnt_q    <= CntW'(1);
            IN_READY <= 1'b0;
            ENG_RST  <= 1'b0;
            BUSY     <= 1'b1;
            state_q  <= StClr;
          end
        end
        StClr: begin
          ENG_RST <= 1'b1;
          state_q <= StGap;
        end
        StGap: begin
          ENG_ACTIVE <= 1'b1;
          ENG_DATA   <= shift_q[0];
          shift_q    <= shift_q >> 1;
          bit_q      <= '0;
          IN_READY   <= ~last_q;
          state_q    <= StShift;
        end
        StShift: begin
          if (overlength || underrun) begin
            ERR        <= 1'b1;
            ENG_RST    <= 1'b0;
            ENG_ACTIVE <= 1'b0;
            ENG_DATA   <= 1'b0;
            IN_READY   <= 1'b0;
            pf_valid_q <= 1'b0;
            state_q    <= StAbort;
          end else if (bit_end && last_q) begin
            ENG_ACTIVE <= 1'b0;
            ENG_DATA   <= 1'b0;
            IN_READY   <= 1'b0;
            crc_idx_q  <= '0;
            tmo_q      <= '0;
            state_q    <= StDrain;
          end else if (bit_end) begin
            bit_q <= '0;
            if (pf_valid_q) begin
              ENG_DATA   <= pf_data_q[0];
              shift_q    <= pf_data_q >> 1;
              last_q     <= pf_last_q;
              pf_valid_q <= 1'b0;
              IN_READY   <= ~pf_last_q;
            end else begin
              ENG_DATA <= IN_DATA[0];
              shift_q  <= IN_DATA >> 1;
              last_q   <= IN_LAST;
              cnt_q    <= cnt_q + 1'b1;
              IN_READY <= ~IN_LAST;
            end
          end else begin
            bit_q    <= bit_q + 1'b1;
            ENG_DATA <= shift_q[0];
            shift_q  <= shift_q >> 1;
            if (accept) begin
              pf_data_q  <= IN_DATA;
              pf_last_q  <= IN_LAST;
              pf_valid_q <= 1'b1;
              cnt_q      <= cnt_q + 1'b1;
              IN_READY   <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (ENG_VALID) begin
            OUT_CRC[crc_pos] <= ENG_CRC;
            crc_idx_q        <= crc_idx_q + 1'b1;
            if (crc_idx_q == CrcIdxW'(CRC_W - 1)) begin
              OUT_VALID <= 1'b1;
              state_q   <= StHold;
            end
          end else if (crc_idx_q == '0) begin
            // The timeout only guards the wait for the first CRC bit.
            if (tmo_q == TmoW'(TIMEOUT - 1)) begin
              ERR     <= 1'b1;
              ENG_RST <= 1'b0;
              state_q <= StAbort;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            BUSY      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StAbort: begin
          ENG_RST  <= 1'b1;
          IN_READY <= 1'b1;
          BUSY     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: serial CRC-8 (poly 0x07) engine model plus a result/error scoreboard.
module tb_crc_frame_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN_DATA = '0;
  logic       IN_LAST = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY, ENG_RST, ENG_DATA, ENG_ACTIVE, ENG_CRC, ENG_VALID;
  logic [7:0] OUT_CRC;
  logic       OUT_VALID, BUSY, ERR;
  logic       OUT_READY = 1'b1;

  always #5 CLK = ~CLK;

  crc_frame_ctrl #(.DATA_W(8), .CRC_W(8), .MAX_BYTES(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .ENG_RST(ENG_RST), .ENG_DATA(ENG_DATA), .ENG_ACTIVE(ENG_ACTIVE),
    .ENG_CRC(ENG_CRC), .ENG_VALID(ENG_VALID), .OUT_CRC(OUT_CRC), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BUSY(BUSY), .ERR(ERR)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: serial CRC-8, data LSB-first into an MSB-out register; bit j of crc emitted j-th.
  logic [7:0] eng_crc = '0;
  logic       eng_has = 1'b0;
  logic [2:0] eng_idx = '0;
  logic       eng_en  = 1'b1;
  always @(posedge CLK) begin
    if (!ENG_RST) begin
      eng_crc <= '0;
      eng_has <= 1'b0;
      eng_idx <= '0;
    end else if (ENG_ACTIVE) begin
      eng_crc <= {eng_crc[6:0], 1'b0} ^ (((eng_crc[7] ^ ENG_DATA) != 1'b0) ? 8'h07 : 8'h00);
      eng_has <= 1'b1;
      eng_idx <= '0;
    end else if (ENG_VALID) begin
      eng_idx <= eng_idx + 3'd1;
      if (eng_idx == 3'd7) eng_has <= 1'b0;
    end
  end
  assign ENG_VALID = eng_en & eng_has & ~ENG_ACTIVE;
  assign ENG_CRC   = eng_crc[eng_idx];

  function automatic logic [7:0] exp_crc(input logic [7:0] c);
    logic [7:0] r;
    r = c;
`ifdef CRC_OUT_REFLECT_EN
    for (int i = 0; i < 8; i++) r[i] = c[7-i];
`endif
    return r;
  endfunction

  typedef struct {
    bit         is_err;
    logic [7:0] crc;
  } exp_t;
  exp_t sb[$];

  // Monitor: every result handshake and every ERR pulse consumes one scoreboard entry.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (ERR) begin
        chk("err_vs_valid", OUT_VALID, 1'b0);
        chk("err_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("err_kind", e.is_err, 1'b1);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        chk("result_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result_kind", e.is_err, 1'b0);
          if (!e.is_err) chk("out_crc", OUT_CRC, e.crc);
        end
      end
    end
  end

  int   act_cyc = 0, act_rise = 0, rst_low = 0;
  logic act_prev = 1'b0;
  always @(negedge CLK) begin
    if (ENG_ACTIVE) act_cyc++;
    if (ENG_ACTIVE && !act_prev) act_rise++;
    if (RST && !ENG_RST) rst_low++;
    act_prev = ENG_ACTIVE;
  end

  // Called at a negedge; returns at the negedge after the accepting edge (cycle 1 of a frame).
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    IN_DATA  = d;
    IN_LAST  = l;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("accept_wait", IN_READY, 1'b1);
    @(negedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(name, BUSY, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         n;
    exp_t       e;

    repeat (3) @(negedge CLK);
    chk("reset_outputs",
        {IN_READY, ENG_RST, ENG_ACTIVE, ENG_DATA, OUT_VALID, BUSY, ERR, OUT_CRC}, '0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", IN_READY, 1'b1);
    chk("idle_eng_rst", ENG_RST, 1'b1);

    // Single byte 0xA5 with exact cycle timing; engine CRC hand-computed as 0x72.
    e = '{is_err: 1'b0, crc: exp_crc(8'h72)};
    sb.push_back(e);
    b = 8'hA5;
    send(b, 1'b1);
    IN_VALID = 1'b0;
    chk("t1_eng_rst_c1", ENG_RST, 1'b0);
    chk("t1_in_ready_c1", IN_READY, 1'b0);
    @(negedge CLK);
    chk("t1_eng_rst_c2", ENG_RST, 1'b1);
    chk("t1_active_c2", ENG_ACTIVE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("t1_active_shift", ENG_ACTIVE, 1'b1);
      chk("t1_eng_data", ENG_DATA, b[i]);
    end
    @(negedge CLK);
    chk("t1_active_c11", ENG_ACTIVE, 1'b0);
    repeat (7) @(negedge CLK);
    chk("t1_out_valid_c18", OUT_VALID, 1'b0);
    @(negedge CLK);
    chk("t1_out_valid_c19", OUT_VALID, 1'b1);
    @(negedge CLK);
    chk("t1_out_valid_c20", OUT_VALID, 1'b0);
    chk("t1_busy_c20", BUSY, 1'b0);

    // Three back-to-back bytes; CRC hand-computed as 0x1E.
    act_cyc = 0; act_rise = 0; rst_low = 0;
    e = '{is_err: 1'b0, crc: exp_crc(8'h1E)};
    sb.push_back(e);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    IN_VALID = 1'b0;
    wait_idle("t2_idle");
    chk("t2_active_cycles", act_cyc, 24);
    chk("t2_active_runs", act_rise, 1);
    chk("t2_eng_rst_pulses", rst_low, 1);

    // Underrun: one non-last byte, then nothing.
    e = '{is_err: 1'b1, crc: 8'h00};
    sb.push_back(e);
    send(8'h11, 1'b0);
    IN_VALID = 1'b0;
    repeat (9) @(negedge CLK);
    chk("t3_err_c10", ERR, 1'b0);
    @(negedge CLK);
    chk("t3_err_c11", ERR, 1'b1);
    chk("t3_eng_rst_abort", ENG_RST, 1'b0);
    @(negedge CLK);
    chk("t3_err_c12", ERR, 1'b0);
    chk("t3_busy_c12", BUSY, 1'b0);

    // Overlength: 17 bytes, none marked last.
    e = '{is_err: 1'b1, crc: 8'h00};
    sb.push_back(e);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      send(b, 1'b0);
    end
    IN_VALID = 1'b0;
    chk("t4_err_after_17", ERR, 1'b1);
    wait_idle("t4_idle");

    // Timeout: engine never raises Valid.
    eng_en = 1'b0;
    e = '{is_err: 1'b1, crc: 8'h00};
    sb.push_back(e);
    send(8'hA5, 1'b1);
    IN_VALID = 1'b0;
    repeat (13) @(negedge CLK);
    chk("t5_err_c14", ERR, 1'b0);
    @(negedge CLK);
    chk("t5_err_c15", ERR, 1'b1);
    wait_idle("t5_idle");
    eng_en = 1'b1;

    // Backpressure: result must hold and block new frames.
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    @(negedge CLK);
    e = '{is_err: 1'b0, crc: exp_crc(8'h72)};
    sb.push_back(e);
    send(8'hA5, 1'b1);
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_out_valid", OUT_VALID, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold_crc", OUT_CRC, exp_crc(8'h72));
      chk("t6_hold_in_ready", IN_READY, 1'b0);
      @(negedge CLK);
    end
    chk("t6_still_valid", OUT_VALID, 1'b1);
    @(posedge CLK);
    #1 OUT_READY = 1'b1;
    @(negedge CLK);
    wait_idle("t6_idle");

    // Reset in the middle of SHIFT discards the frame.
    send(8'h5A, 1'b1);
    IN_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t6_mid_shift", ENG_ACTIVE, 1'b1);
    RST = 1'b0;
    #1;
    chk("t6_reset_outputs",
        {IN_READY, ENG_RST, ENG_ACTIVE, ENG_DATA, OUT_VALID, BUSY, ERR, OUT_CRC}, '0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    e = '{is_err: 1'b0, crc: exp_crc(8'h72)};
    sb.push_back(e);
    send(8'hA5, 1'b1);
    IN_VALID = 1'b0;
    wait_idle("t6_post_reset_idle");

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
